// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
//
// Shared definitions for the parallel-in/serial-out serializer.
//
// Contents:
//   state_e      - controller state (IDLE: waiting for a word, SHIFT: streaming)
//   PARITY_BITS  - 1 when PISO_PARITY_EN is defined, otherwise 0
//   cnt_width()  - width of the per-frame bit counter for a given word width
//   frame_bits() - number of enabled cycles a frame occupies on the serial
//                  output (data bits plus the optional parity bit)
//
// Configuration macro: PISO_PARITY_EN (undefined by default).
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Counter must be able to hold WIDTH, the load value of a parity frame.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_bits(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in/serial-out shifter. A WIDTH-bit word is accepted over a
// valid/ready handshake and emitted one bit per enabled clock on q, qualified
// by q_valid and q_last. Back-to-back words stream with no gap bits: the next
// word is loaded on the same enabled edge that retires the last bit.
//
// Parameters:
//   WIDTH     - word width in bits (>= 2)
//   LSB_FIRST - 0: MSB shifted out first, 1: LSB shifted out first
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   in_data   in   parallel word to serialize
//   in_valid  in   in_data valid
//   in_ready  out  a word can be accepted this cycle
//   ce        in   shift enable; advances the serial stream one bit
//   q         out  serial data bit (registered)
//   q_valid   out  q carries a frame bit (registered)
//   q_last    out  q is the final bit of the current frame (registered)
//
// Configuration macro: PISO_PARITY_EN. When defined, an even-parity bit (XOR
// of the data bits, latched at load) follows the last data bit, the frame is
// WIDTH+1 enabled cycles long and q_last marks the parity bit only.
// -----------------------------------------------------------------------------
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ce,
    output logic             q,
    output logic             q_valid,
    output logic             q_last
);

    localparam int CNT_W      = cnt_width(WIDTH);
    localparam int FRAME_BITS = frame_bits(WIDTH);

    // The counter holds the number of frame bits still to come after the one
    // currently on q, so it reaches zero exactly on the last bit of the frame.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] shreg_q,   shreg_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             q_q,       q_d;
    logic             q_valid_q, q_valid_d;
    logic             q_last_q,  q_last_d;
`ifdef PISO_PARITY_EN
    logic             parity_q,  parity_d;
`endif

    logic             load;

    // Bit that leaves the word first, in the configured shift order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    // Word with its first-out bit removed, so the next bit moves to the exit end.
    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    // Ready in IDLE regardless of ce; in SHIFT only on the enabled edge that
    // retires the last bit, which lets the next word follow with no bubble.
    // Nothing here looks at in_valid or in_data.
    assign in_ready = !rst && ((state_q == ST_IDLE) || (q_last_q && ce));
    assign load     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        q_last_d  = q_last_q;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif

        if (load) begin
            // The first bit goes straight to the q register; the shift
            // register keeps only the bits that still have to follow.
            state_d   = ST_SHIFT;
            shreg_d   = drop_first(in_data);
            cnt_d     = CNT_LOAD;
            q_d       = first_bit(in_data);
            q_valid_d = 1'b1;
            // WIDTH >= 2, so the first bit is never the last one.
            q_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
            parity_d  = ^in_data;
`endif
        end else if ((state_q == ST_SHIFT) && ce) begin
            if (q_last_q) begin
                // Frame finished and no word waiting: drop back to idle with
                // all serial outputs at their quiescent values.
                state_d   = ST_IDLE;
                shreg_d   = '0;
                cnt_d     = '0;
                q_d       = 1'b0;
                q_valid_d = 1'b0;
                q_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
                parity_d  = 1'b0;
`endif
            end else begin
                cnt_d    = cnt_q - CNT_ONE;
                q_last_d = (cnt_q == CNT_ONE);
                shreg_d  = drop_first(shreg_q);
`ifdef PISO_PARITY_EN
                // With one bit left to go, that bit is the latched parity.
                q_d      = (cnt_q == CNT_ONE) ? parity_q : first_bit(shreg_q);
`else
                q_d      = first_bit(shreg_q);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            q_q       <= 1'b0;
            q_valid_q <= 1'b0;
            q_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_last_q  <= q_last_d;
`ifdef PISO_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_last  = q_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Two serializers (MSB-first and LSB-first) share one stimulus stream. Each
// accepted word is expanded into its expected serial frame (bit value plus
// last flag) and queued per instance. A negedge monitor consumes the frame
// bit by bit on enabled cycles, checks q / q_valid / q_last / in_ready
// against the queue head, and rebuilds the received words from q so they can
// be compared with the words that were sent.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             ce;

    logic             in_ready_m, q_m, qv_m, ql_m;
    logic             in_ready_l, q_l, qv_l, ql_l;

    piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(0)) dut_msb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_m),
        .ce       (ce),
        .q        (q_m),
        .q_valid  (qv_m),
        .q_last   (ql_m)
    );

    piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1)) dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_l),
        .ce       (ce),
        .q        (q_l),
        .q_valid  (qv_l),
        .q_last   (ql_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard state, index 0 = MSB-first instance, 1 = LSB-first instance.
    logic [1:0]       exp_q [2][$];   // {last, bit}
    logic [WIDTH-1:0] rx_q  [2][$];   // words rebuilt from q
    logic [WIDTH-1:0] acc   [2];
    int               bit_idx   [2];
    int               valid_cnt [2];
    int               last_cnt  [2];
    logic [WIDTH-1:0] sent_q[$];
    logic [WIDTH-1:0] pending[$];

    int ce_mode   = 0;     // 0: ce always 1, 1: random ce
    int valid_pct = 100;   // chance of presenting a new word on a cycle
    int stall_lo  = -1;    // cycle window (relative to run start) forcing ce=0
    int stall_hi  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame a word produces, from the bit ordering rule
    // and the even-parity rule.
    task automatic push_word(input logic [WIDTH-1:0] w);
        logic b;
        logic last;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < FRAME; i++) begin
                if (i < WIDTH) b = (d == 0) ? w[WIDTH-1-i] : w[i];
                else           b = ^w;
                last = (i == FRAME - 1);
                exp_q[d].push_back({last, b});
            end
        end
        sent_q.push_back(w);
    endtask

    task automatic mon_dut(input int d, input string tag, input logic qq,
                           input logic qv, input logic ql, input logic rdy);
        logic [1:0] f;
        logic       exp_rdy;
        if (exp_q[d].size() == 0) begin
            exp_rdy = 1'b1;
            check({tag, ".idle_q_valid"}, 32'(qv), 32'd0);
            check({tag, ".idle_q"},       32'(qq), 32'd0);
            check({tag, ".idle_q_last"},  32'(ql), 32'd0);
        end else begin
            f       = exp_q[d][0];
            exp_rdy = f[1] && ce;
            check({tag, ".q_valid"}, 32'(qv), 32'd1);
            check({tag, ".q"},       32'(qq), 32'(f[0]));
            check({tag, ".q_last"},  32'(ql), 32'(f[1]));
            if (ce) begin
                void'(exp_q[d].pop_front());
                valid_cnt[d]++;
                if (f[1]) last_cnt[d]++;
                if (bit_idx[d] < WIDTH) begin
                    if (d == 0) acc[d] = {acc[d][WIDTH-2:0], qq};
                    else        acc[d] = {qq, acc[d][WIDTH-1:1]};
                    bit_idx[d]++;
                    if (bit_idx[d] == WIDTH) rx_q[d].push_back(acc[d]);
                end
                if (f[1]) bit_idx[d] = 0;
            end
        end
        check({tag, ".in_ready"}, 32'(rdy), 32'(exp_rdy));
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                mon_dut(0, "msb", q_m, qv_m, ql_m, in_ready_m);
                mon_dut(1, "lsb", q_l, qv_l, ql_l, in_ready_l);
            end
        end
    end

    task automatic clear_scoreboard();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            rx_q[d].delete();
            bit_idx[d] = 0;
            acc[d]     = '0;
        end
        sent_q.delete();
    endtask

    // Drives pending words until every frame has been observed. Entered and
    // left just after a rising edge.
    task automatic run(input int max_cycles);
        int c       = 0;
        bit holding = 1'b0;
        while (pending.size() > 0 || exp_q[0].size() > 0 || exp_q[1].size() > 0) begin
            if (c >= max_cycles) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: got %0d cycles required < %0d", c, max_cycles);
                break;
            end
            if (!holding && pending.size() > 0 && $urandom_range(0, 99) < valid_pct)
                holding = 1'b1;
            in_valid = holding;
            in_data  = holding ? pending[0] : WIDTH'($urandom);
            ce       = (ce_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (c >= stall_lo && c <= stall_hi) ce = 1'b0;
            @(negedge clk);
            #1;
            if (in_valid && in_ready_m) begin
                push_word(pending.pop_front());
                holding = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        check("end.q_valid_msb", 32'(qv_m), 32'd0);
        check("end.q_valid_lsb", 32'(qv_l), 32'd0);
        check("end.in_ready",    32'(in_ready_m), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, ".word_count"}, 32'(rx_q[d].size()), 32'(sent_q.size()));
            for (int i = 0; i < sent_q.size() && i < rx_q[d].size(); i++)
                check({tag, ".word"}, 32'(rx_q[d][i]), 32'(sent_q[i]));
            rx_q[d].delete();
        end
        sent_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int l0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ce       = 1'b0;
        for (int d = 0; d < 2; d++) begin
            bit_idx[d]   = 0;
            acc[d]       = '0;
            valid_cnt[d] = 0;
            last_cnt[d]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready_m), 32'd0);
        check("rst.q_valid",  32'(qv_m), 32'd0);
        check("rst.q",        32'({q_m, q_l}), 32'd0);
        check("rst.q_last",   32'({ql_m, ql_l}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic single word
        pending = '{8'hA5};
        run(100);
        check_rx("basic");

        // Back-to-back: two frames contiguous, two q_last pulses
        v0 = valid_cnt[0];
        l0 = last_cnt[0];
        pending = '{8'hA5, 8'h3C};
        run(100);
        check("b2b.valid_cycles", 32'(valid_cnt[0] - v0), 32'(2 * FRAME));
        check("b2b.last_pulses",  32'(last_cnt[0] - l0),  32'd2);
        check_rx("b2b");

        // ce stall after the second bit
        stall_lo = 2;
        stall_hi = 4;
        pending  = '{8'hF0};
        run(100);
        stall_lo = -1;
        stall_hi = -1;
        check_rx("stall");

        // LSB-first corner word
        pending = '{8'h01};
        run(100);
        check_rx("lsb");

        // Parity examples (plain data words when parity is disabled)
        pending = '{8'h07, 8'hA5};
        run(100);
        check_rx("parity");

        // Reset in the middle of 0xFF
        in_valid = 1'b1;
        in_data  = 8'hFF;
        ce       = 1'b1;
        @(negedge clk);
        #1;
        if (in_ready_m) push_word(8'hFF);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("pre_rst.q_valid", 32'(qv_m), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst.q_valid", 32'({qv_m, qv_l}), 32'd0);
        check("async_rst.q",       32'({q_m, q_l}),   32'd0);
        check("async_rst.q_last",  32'({ql_m, ql_l}), 32'd0);
        check("async_rst.in_ready", 32'({in_ready_m, in_ready_l}), 32'd0);
        clear_scoreboard();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pending = '{8'h00};
        run(100);
        check_rx("after_rst");

        // Random words, random ce, random valid gaps
        ce_mode   = 1;
        valid_pct = 60;
        for (int i = 0; i < 40; i++) pending.push_back(WIDTH'($urandom));
        run(4000);
        check_rx("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
